// File: rtl/spi_regmap_pkg.sv
// Shared constants for the DSP core SPI register map and the master FSM encoding.
package spi_regmap_pkg;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 24;
    localparam int FRAME_BITS = 32;
    localparam logic RW_READ  = 1'b1;

    localparam logic [ADDR_W-1:0] REG_CTRL          = 7'h00;
    localparam logic [ADDR_W-1:0] REG_FIR_SHIFT     = 7'h01;
    localparam logic [ADDR_W-1:0] REG_FIR_COEF_BASE = 7'h40;
    localparam logic [ADDR_W-1:0] REG_DEV_ID        = 7'h7F;

    localparam int CTRL_RESET_BIT = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction
endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: half-period counter, SCK toggle and edge/sample strobes.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick,
    output logic sample_tick
);
    localparam int HC_W = $clog2(CLK_DIV);
    localparam logic [HC_W-1:0] HC_ZERO = HC_W'(32'd0);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(32'd1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

    logic [HC_W-1:0] hcnt_r;
    logic            sck_r;
    logic            wrap_s;

    assign wrap_s = en && (hcnt_r == HC_LAST);

    // Half-period counter; SCK is forced low whenever the generator is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= HC_ZERO;
            sck_r  <= 1'b0;
        end else if (!en) begin
            hcnt_r <= HC_ZERO;
            sck_r  <= 1'b0;
        end else if (wrap_s) begin
            hcnt_r <= HC_ZERO;
            sck_r  <= ~sck_r;
        end else begin
            hcnt_r <= hcnt_r + HC_ONE;
            sck_r  <= sck_r;
        end
    end

    // Strobes mark the cycle before the edge, so the last high cycle doubles as the sample point
    assign sck         = sck_r;
    assign rise_tick   = wrap_s && !sck_r;
    assign fall_tick   = wrap_s && sck_r;
    assign sample_tick = wrap_s && sck_r;
endmodule

// File: rtl/soft_spi_master.sv
// Mode-0 SPI initiator issuing one {rw, addr, data} 32-bit frame per start request.
module soft_spi_master
    import spi_regmap_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sck,
    output logic              ncs,
    output logic              mosi,
    input  logic              miso
);
    if (CLK_DIV < 3) begin : g_clk_div_check
        $error("soft_spi_master: CLK_DIV must be at least 3");
    end

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [4:0] BIT_FIRST = 5'(FRAME_BITS - 1);
    localparam logic [4:0] DATA_BITS = 5'(DATA_W);

    spi_state_e            state_r, state_nx_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [4:0]            bit_cnt_r;
    logic [FRAME_BITS-1:0] tx_sr_r;
    logic [DATA_W-1:0]     rx_sr_r, rdata_r;
    logic                  miso_meta_r, miso_sync_r;
    logic                  ncs_r, busy_r, done_r, mosi_r;
    logic                  sck_s, rise_tick_s, fall_tick_s, sample_tick_s;
    logic                  accept_s, shift_s, done_set_s, rise_unused_s;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (state_r == ST_SHIFT),
        .sck         (sck_s),
        .rise_tick   (rise_tick_s),
        .fall_tick   (fall_tick_s),
        .sample_tick (sample_tick_s)
    );

    assign rise_unused_s = rise_tick_s;
    assign accept_s   = start && (state_r == ST_IDLE);
    assign shift_s    = (state_r == ST_SHIFT) && fall_tick_s && (bit_cnt_r != 5'd0);
    assign done_set_s = (state_r == ST_HOLD) && (state_nx_s == ST_GAP);

    // Next-state logic; the bit counter holds at 0 so the 32nd falling edge ends SHIFT
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_nx_s = ST_SETUP; else state_nx_s = ST_IDLE;
            ST_SETUP: if (cnt_r == SETUP_LAST) state_nx_s = ST_SHIFT; else state_nx_s = ST_SETUP;
            ST_SHIFT: if (fall_tick_s && (bit_cnt_r == 5'd0)) state_nx_s = ST_HOLD; else state_nx_s = ST_SHIFT;
            ST_HOLD:  if (cnt_r == HOLD_LAST) state_nx_s = ST_GAP; else state_nx_s = ST_HOLD;
            ST_GAP:   if (cnt_r == IDLE_LAST) state_nx_s = ST_IDLE; else state_nx_s = ST_GAP;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // State register and per-state cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (state_nx_s != state_r) cnt_r <= {CNT_W{1'b0}};
            else                       cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Transmit shift register, bit counter and MOSI; MOSI only moves on SCK falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 5'd0;
            tx_sr_r   <= {FRAME_BITS{1'b0}};
            mosi_r    <= 1'b0;
        end else if (accept_s) begin
            bit_cnt_r <= BIT_FIRST;
            tx_sr_r   <= make_frame(rw, addr, wdata);
            mosi_r    <= rw;
        end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r - 5'd1;
            tx_sr_r   <= {tx_sr_r[FRAME_BITS-2:0], 1'b0};
            mosi_r    <= tx_sr_r[FRAME_BITS-2];
        end else if (done_set_s) begin
            mosi_r    <= 1'b0;
        end else begin
            mosi_r    <= mosi_r;
        end
    end

    // MISO synchroniser and data-phase capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_r <= 1'b0;
            miso_sync_r <= 1'b0;
            rx_sr_r     <= {DATA_W{1'b0}};
        end else begin
            miso_meta_r <= miso;
            miso_sync_r <= miso_meta_r;
            if (accept_s)
                rx_sr_r <= {DATA_W{1'b0}};
            else if ((state_r == ST_SHIFT) && sample_tick_s && (bit_cnt_r < DATA_BITS))
                rx_sr_r <= {rx_sr_r[DATA_W-2:0], miso_sync_r};
            else
                rx_sr_r <= rx_sr_r;
        end
    end

    // Registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            ncs_r  <= (state_nx_s == ST_IDLE) || (state_nx_s == ST_GAP);
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= done_set_s;
            if (done_set_s) rdata_r <= rx_sr_r;
            else            rdata_r <= rdata_r;
        end
    end

    assign sck   = sck_s;
    assign ncs   = ncs_r;
    assign mosi  = mosi_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign rdata = rdata_r;
endmodule

// File: tb/tb_soft_spi_master.sv
// Self-checking bench for soft_spi_master with a behavioural mode-0 SPI slave.
module tb_soft_spi_master;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
    localparam int DONE_LAT = 1 + CS_SETUP + 64 * CLK_DIV + CS_HOLD;
    localparam int IDLE_LAT = DONE_LAT + CS_IDLE;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rw = 1'b0, miso = 1'b0;
    logic [6:0]  addr = 7'h00;
    logic [23:0] wdata = 24'h000000;
    logic        busy, done, sck, ncs, mosi;
    logic [23:0] rdata;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] resp_q[$];
    int rise_cnt = 0, ncs_fall_cnt = 0, done_cnt = 0, mosi_viol = 0, sck_viol = 0;
    logic [31:0] mosi_word = 32'h0;
    logic prev_sck = 1'b0, prev_ncs = 1'b1, prev_mosi = 1'b0;

    soft_spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .sck(sck), .ncs(ncs), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: presents bit 31 on ncs fall, next bit after each SCK fall
    initial begin
        logic [31:0] sh;
        forever begin
            @(negedge ncs);
            if (resp_q.size() > 0) sh = resp_q.pop_front();
            else                   sh = $urandom;
            miso = sh[31];
            while (ncs === 1'b0) begin
                @(negedge sck or posedge ncs);
                if (ncs === 1'b0) begin
                    sh   = {sh[30:0], 1'b0};
                    miso = sh[31];
                end
            end
        end
    end

    // Bus monitor sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (ncs === 1'b1 && sck === 1'b1) sck_viol++;
            if (prev_ncs === 1'b1 && ncs === 1'b0) begin
                ncs_fall_cnt++;
                rise_cnt = 0;
            end else if (ncs === 1'b0 && prev_ncs === 1'b0 && mosi !== prev_mosi &&
                         !(prev_sck === 1'b1 && sck === 1'b0)) begin
                mosi_viol++;
            end
            if (ncs === 1'b0 && prev_sck === 1'b0 && sck === 1'b1) begin
                rise_cnt++;
                mosi_word = {mosi_word[30:0], mosi};
            end
            if (done === 1'b1) done_cnt++;
            prev_sck = sck; prev_ncs = ncs; prev_mosi = mosi;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic run_frame(input logic rw_i, input logic [6:0] a_i, input logic [23:0] d_i,
                             output int t_ncs, output int t_done, output int t_idle,
                             output logic [23:0] rd, output logic [31:0] mw, output int rises, output bit tmo);
        int t0;
        t_ncs = -1; t_done = -1; t_idle = -1; rd = 24'h0; mw = 32'h0; rises = 0; tmo = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 400 && busy !== 1'b0; n++) @(negedge clk);
        rw = rw_i; addr = a_i; wdata = d_i; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (t_ncs < 0 && ncs === 1'b0) t_ncs = cyc - t0;
            if (done === 1'b1 && t_done < 0) begin
                t_done = cyc - t0; rd = rdata; mw = mosi_word; rises = rise_cnt;
            end
            if (busy === 1'b0) begin t_idle = cyc - t0; tmo = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (sck !== 1'b0)      begin failures++; $display("FAIL reset_sck got=%b exp=0", sck); end
        checks++; if (ncs !== 1'b1)      begin failures++; $display("FAIL reset_ncs got=%b exp=1", ncs); end
        checks++; if (mosi !== 1'b0)     begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rdata !== 24'h0)   begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_devid();
        int tn, td, ti, rs; logic [23:0] rd, wd; logic [31:0] mw; bit tmo;
        wd = 24'($urandom);
        resp_q.delete();
        resp_q.push_back({8'($urandom), 24'hF0CCAB});
        run_frame(1'b1, 7'h7F, wd, tn, td, ti, rd, mw, rs, tmo);
        checks++; if (tmo !== 1'b0)        begin failures++; $display("FAIL devid_timeout got=%b exp=0", tmo); end
        checks++; if (mw[31:24] !== 8'hFF) begin failures++; $display("FAIL devid_cmd got=%h exp=ff", mw[31:24]); end
        checks++; if (mw[23:0] !== wd)     begin failures++; $display("FAIL devid_wdata got=%h exp=%h", mw[23:0], wd); end
        checks++; if (rd !== 24'hF0CCAB)   begin failures++; $display("FAIL devid_rdata got=%h exp=f0ccab", rd); end
        checks++; if (rs !== 32)           begin failures++; $display("FAIL devid_rises got=%0d exp=32", rs); end
    endtask

    task automatic test_write_fir();
        int tn, td, ti, rs, v0; logic [23:0] rd; logic [31:0] mw, resp; bit tmo;
        resp = $urandom;
        v0 = mosi_viol;
        resp_q.delete();
        resp_q.push_back(resp);
        run_frame(1'b0, 7'h01, 24'h000010, tn, td, ti, rd, mw, rs, tmo);
        checks++; if (mw !== 32'h01000010)   begin failures++; $display("FAIL fir_mosi got=%h exp=01000010", mw); end
        checks++; if (mosi_viol !== v0)      begin failures++; $display("FAIL fir_mosi_stable got=%0d exp=%0d", mosi_viol, v0); end
        checks++; if (rs !== 32)             begin failures++; $display("FAIL fir_rises got=%0d exp=32", rs); end
        checks++; if (rd !== resp[23:0])     begin failures++; $display("FAIL fir_rdata got=%h exp=%h", rd, resp[23:0]); end
    endtask

    task automatic test_timing();
        int tn, td, ti, rs; logic [23:0] rd, wd; logic [31:0] mw, resp; logic [6:0] a; logic r; bit tmo;
        for (int k = 0; k < 3; k++) begin
            resp = $urandom; wd = 24'($urandom); a = 7'($urandom); r = 1'($urandom);
            resp_q.delete();
            resp_q.push_back(resp);
            run_frame(r, a, wd, tn, td, ti, rd, mw, rs, tmo);
            checks++; if (tn !== 1)              begin failures++; $display("FAIL tim_ncs got=%0d exp=1", tn); end
            checks++; if (td !== DONE_LAT)       begin failures++; $display("FAIL tim_done got=%0d exp=%0d", td, DONE_LAT); end
            checks++; if (ti !== IDLE_LAT)       begin failures++; $display("FAIL tim_busy got=%0d exp=%0d", ti, IDLE_LAT); end
            checks++; if (rd !== resp[23:0])     begin failures++; $display("FAIL tim_rdata got=%h exp=%h", rd, resp[23:0]); end
            checks++; if (mw !== {r, a, wd})     begin failures++; $display("FAIL tim_mosi got=%h exp=%h", mw, {r, a, wd}); end
        end
        checks++; if (sck_viol !== 0) begin failures++; $display("FAIL sck_idle_low got=%0d exp=0", sck_viol); end
    endtask

    task automatic test_start_while_busy();
        int nf0, d0; logic [23:0] rd, wd; logic [31:0] resp, mw; bit seen;
        resp = $urandom; wd = 24'($urandom); seen = 1'b0; rd = 24'h0; mw = 32'h0;
        resp_q.delete();
        resp_q.push_back(resp);
        @(negedge clk);
        for (int n = 0; n < 400 && busy !== 1'b0; n++) @(negedge clk);
        nf0 = ncs_fall_cnt; d0 = done_cnt;
        rw = 1'b1; addr = 7'h40; wdata = wd; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
        rw = 1'b0; addr = 7'h00; wdata = ~wd; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (done === 1'b1) begin seen = 1'b1; rd = rdata; mw = mosi_word; end
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (ncs_fall_cnt - nf0 !== 1) begin failures++; $display("FAIL busy_frames got=%0d exp=1", ncs_fall_cnt - nf0); end
        checks++; if (done_cnt - d0 !== 1)      begin failures++; $display("FAIL busy_dones got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy !== 1'b0)            begin failures++; $display("FAIL busy_queued got=%b exp=0", busy); end
        checks++; if (seen !== 1'b1 || rd !== resp[23:0]) begin failures++; $display("FAIL busy_rdata got=%h exp=%h", rd, resp[23:0]); end
        checks++; if (mw !== {1'b1, 7'h40, wd}) begin failures++; $display("FAIL busy_mosi got=%h exp=%h", mw, {1'b1, 7'h40, wd}); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, tn, td, ti, rs; logic [23:0] rd, wd; logic [31:0] mw, resp; bit tmo;
        resp_q.delete();
        resp_q.push_back(32'($urandom));
        @(negedge clk);
        for (int n = 0; n < 400 && busy !== 1'b0; n++) @(negedge clk);
        rw = 1'b1; addr = 7'h7F; wdata = 24'($urandom); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 400 && rise_cnt < 11; n++) @(negedge clk);
        checks++; if (rise_cnt < 11) begin failures++; $display("FAIL mid_reach got=%0d exp=11", rise_cnt); end
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ncs !== 1'b1)    begin failures++; $display("FAIL mid_ncs got=%b exp=1", ncs); end
        checks++; if (sck !== 1'b0)    begin failures++; $display("FAIL mid_sck got=%b exp=0", sck); end
        checks++; if (rdata !== 24'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, d0); end
        resp = $urandom; wd = 24'($urandom);
        resp_q.delete();
        resp_q.push_back(resp);
        run_frame(1'b1, 7'h01, wd, tn, td, ti, rd, mw, rs, tmo);
        checks++; if (rd !== resp[23:0])       begin failures++; $display("FAIL mid_next_rdata got=%h exp=%h", rd, resp[23:0]); end
        checks++; if (mw !== {8'h81, wd})      begin failures++; $display("FAIL mid_next_mosi got=%h exp=%h", mw, {8'h81, wd}); end
        checks++; if (rs !== 32 || td !== DONE_LAT) begin failures++; $display("FAIL mid_next_frame got=%0d/%0d exp=32/%0d", rs, td, DONE_LAT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] resps[3]; logic [23:0] wd; logic [6:0] a; logic prev_l;
        int k, rise_cyc, ngaps;
        wd = 24'($urandom); a = 7'($urandom); k = 0; rise_cyc = -1; ngaps = 0;
        resp_q.delete();
        for (int i = 0; i < 3; i++) begin resps[i] = $urandom; resp_q.push_back(resps[i]); end
        @(negedge clk);
        for (int n = 0; n < 400 && busy !== 1'b0; n++) @(negedge clk);
        rw = 1'b1; addr = a; wdata = wd; start = 1'b1;
        prev_l = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (prev_l === 1'b1 && ncs === 1'b0 && rise_cyc >= 0) begin
                ngaps++;
                checks++; if (cyc - rise_cyc < CS_IDLE) begin failures++; $display("FAIL b2b_gap got=%0d exp>=%0d", cyc - rise_cyc, CS_IDLE); end
            end
            if (prev_l === 1'b0 && ncs === 1'b1) rise_cyc = cyc;
            prev_l = ncs;
            if (done === 1'b1) begin
                checks++; if (rdata !== resps[k][23:0]) begin failures++; $display("FAIL b2b_rdata%0d got=%h exp=%h", k, rdata, resps[k][23:0]); end
                checks++; if (mosi_word !== {1'b1, a, wd}) begin failures++; $display("FAIL b2b_mosi%0d got=%h exp=%h", k, mosi_word, {1'b1, a, wd}); end
                k++;
                if (k == 3) begin start = 1'b0; break; end
            end
        end
        start = 1'b0;
        checks++; if (k !== 3)     begin failures++; $display("FAIL b2b_frames got=%0d exp=3", k); end
        checks++; if (ngaps !== 2) begin failures++; $display("FAIL b2b_gaps got=%0d exp=2", ngaps); end
    endtask

    initial begin
        test_reset();
        test_read_devid();
        test_write_fir();
        test_timing();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
